// File: rtl/asteroids_pkg.sv
// Shared types and screen constants for the asteroids video/game blocks.
// Holds the 10-bit coordinate type and a vertical span test used by sprite layers.
package asteroids_pkg;

  localparam int COORD_W        = 10;
  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int SHIP_Y_DEFAULT = 240;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= p <= lo + len - 1; the upper bound is one bit wider so it never wraps.
  function automatic logic in_span(input coord_t p, input coord_t lo, input coord_t len);
    logic [COORD_W:0] hi;
    hi = {1'b0, lo} + {1'b0, len} - (COORD_W+1)'(1);
    return (p >= lo) && ({1'b0, p} <= hi);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: holds active/bx/by, moves up SPEED pixels per tick,
// retires when it would cross row 0, and reports whether it covers (x, y).
module bullet_slot
  import asteroids_pkg::*;
#(
  parameter int SPEED    = 4,
  parameter int BULLET_H = 4
) (
  input  logic   clk_60hz,
  input  logic   reset,
  input  logic   spawn,
  input  coord_t spawn_x,
  input  coord_t spawn_y,
  input  coord_t x,
  input  coord_t y,
  output logic   active,
  output logic   active_nxt,
  output coord_t bx,
  output coord_t by,
  output logic   hit
);

  localparam coord_t SPEED_C = coord_t'(SPEED);
  localparam coord_t H_C     = coord_t'(BULLET_H);

  logic   active_q, active_d;
  coord_t bx_q, bx_d;
  coord_t by_q, by_d;

  // Allocation only targets free slots, so spawn and movement never overlap.
  always_comb begin
    active_d = active_q;
    bx_d     = bx_q;
    by_d     = by_q;
    if (spawn) begin
      active_d = 1'b1;
      bx_d     = spawn_x;
      by_d     = spawn_y;
    end else if (active_q) begin
      if (by_q < SPEED_C) begin
        active_d = 1'b0;
      end else begin
        by_d = by_q - SPEED_C;
      end
    end
  end

  always_ff @(posedge clk_60hz) begin
    if (reset) begin
      active_q <= 1'b0;
      bx_q     <= '0;
      by_q     <= '0;
    end else begin
      active_q <= active_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
    end
  end

  assign active     = active_q;
  assign active_nxt = reset ? 1'b0 : active_d;
  assign bx         = bx_q;
  assign by         = by_q;
  assign hit        = active_q && (x == bx_q) && in_span(y, by_q, H_C);

endmodule

// File: rtl/bullet_launcher.sv
// Spawns bullets from the ship nose on fire, moves them up once per frame tick,
// and renders the bullet pixel layer. Define BULLET_AUTOFIRE_EN for level-triggered fire.
module bullet_launcher
  import asteroids_pkg::*;
#(
  parameter int MAX_BULLETS = 4,
  parameter int SPEED       = 4,
  parameter int COOLDOWN    = 8,
  parameter int SHIP_Y      = SHIP_Y_DEFAULT,
  parameter int NOSE_OFFSET = 12,
  parameter int BULLET_H    = 4
) (
  input  logic       clk_60hz,
  input  logic       reset,
  input  logic       fire,
  input  logic [9:0] ship_x,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       pixel,
  output logic [3:0] active_count,
  output logic       shot_fired
);

  localparam int              CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam coord_t          SPAWN_Y = coord_t'(SHIP_Y - NOSE_OFFSET);

  logic [MAX_BULLETS-1:0] slot_active, slot_active_nxt, slot_hit;
  logic [MAX_BULLETS-1:0] alloc_vec, spawn_vec;
  coord_t                 slot_bx [MAX_BULLETS];
  coord_t                 slot_by [MAX_BULLETS];

  logic            fire_prev_q, fire_prev_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic            shot_fired_q, shot_fired_d;
  logic [3:0]      active_count_q, active_count_d;
  logic            request, fire_ok;

`ifdef BULLET_AUTOFIRE_EN
  assign request = fire;
`else
  assign request = fire & ~fire_prev_q;
`endif

  // Lowest-index slot that is free at the start of this tick.
  always_comb begin
    alloc_vec = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (!slot_active[i] && (alloc_vec == '0)) begin
        alloc_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    fire_prev_d  = fire;
    fire_ok      = request && (cooldown_q == '0) && (alloc_vec != '0);
    spawn_vec    = fire_ok ? alloc_vec : '0;
    shot_fired_d = fire_ok;
    if (fire_ok) begin
      cooldown_d = CD_LOAD;
    end else if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end else begin
      cooldown_d = '0;
    end
    active_count_d = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      active_count_d = active_count_d + 4'(slot_active_nxt[i]);
    end
  end

  // The fire history tracks the button even during reset so a held button is not an edge.
  always_ff @(posedge clk_60hz) begin
    fire_prev_q <= fire_prev_d;
  end

  always_ff @(posedge clk_60hz) begin
    if (reset) begin
      cooldown_q     <= '0;
      shot_fired_q   <= 1'b0;
      active_count_q <= '0;
    end else begin
      cooldown_q     <= cooldown_d;
      shot_fired_q   <= shot_fired_d;
      active_count_q <= active_count_d;
    end
  end

  for (genvar i = 0; i < MAX_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .SPEED    (SPEED),
      .BULLET_H (BULLET_H)
    ) u_slot (
      .clk_60hz   (clk_60hz),
      .reset      (reset),
      .spawn      (spawn_vec[i]),
      .spawn_x    (ship_x),
      .spawn_y    (SPAWN_Y),
      .x          (x),
      .y          (y),
      .active     (slot_active[i]),
      .active_nxt (slot_active_nxt[i]),
      .bx         (slot_bx[i]),
      .by         (slot_by[i]),
      .hit        (slot_hit[i])
    );
  end

  // Slot positions are only consumed inside the slots' own hit tests.
  logic unused_slot_pos;
  always_comb begin
    unused_slot_pos = fire_prev_q;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      unused_slot_pos = unused_slot_pos ^ (^slot_bx[i]) ^ (^slot_by[i]);
    end
  end

  assign pixel        = |slot_hit;
  assign active_count = active_count_q;
  assign shot_fired   = shot_fired_q;

endmodule

// File: tb/tb_bullet_launcher.sv
// Directed bench for bullet_launcher: spawn, flight/retire, cooldown, full slots,
// held fire across reset and reset during flight.
module tb_bullet_launcher;

  logic       clk_60hz = 1'b0;
  logic       reset = 1'b1;
  logic       fire = 1'b0;
  logic [9:0] ship_x = '0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       pixel;
  logic [3:0] active_count;
  logic       shot_fired;

  int total = 0;
  int bad = 0;

  bullet_launcher dut (
    .clk_60hz     (clk_60hz),
    .reset        (reset),
    .fire         (fire),
    .ship_x       (ship_x),
    .x            (x),
    .y            (y),
    .pixel        (pixel),
    .active_count (active_count),
    .shot_fired   (shot_fired)
  );

  // ---------------- clock ----------------
  initial forever #10 clk_60hz = ~clk_60hz;

  // ---------------- drivers ----------------
  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge clk_60hz);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fire  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    fire  = 1'b0;
    step();
    step();
    total++; if (shot_fired !== 1'b0) begin bad++; $display("FAIL reset_shot: got %0b want 0", shot_fired); end
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", active_count); end
    x = 10'd0; y = 10'd0; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL reset_pixel: got %0b want 0", pixel); end
    reset = 1'b0;
    step();
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL reset_idle_count: got %0d want 0", active_count); end
  endtask

  task automatic test_spawn();
    logic exp;
    do_reset();
    ship_x = 10'd100;
    fire   = 1'b1;
    step();
    total++; if (shot_fired !== 1'b1) begin bad++; $display("FAIL spawn_shot: got %0b want 1", shot_fired); end
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL spawn_count: got %0d want 1", active_count); end
    x = 10'd100;
    for (int k = 0; k < 6; k++) begin
      y = 10'(227 + k);
      exp = (k >= 1) && (k <= 4);
      #1;
      total++; if (pixel !== exp) begin bad++; $display("FAIL spawn_pixel y=%0d: got %0b want %0b", y, pixel, exp); end
    end
    x = 10'd101; y = 10'd228; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL spawn_pixel_x101: got %0b want 0", pixel); end
    fire = 1'b0;
    step();
    total++; if (shot_fired !== 1'b0) begin bad++; $display("FAIL spawn_pulse_width: got %0b want 0", shot_fired); end
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL move_count: got %0d want 1", active_count); end
    x = 10'd100; y = 10'd224; #1;
    total++; if (pixel !== 1'b1) begin bad++; $display("FAIL move_pixel_224: got %0b want 1", pixel); end
    y = 10'd223; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL move_pixel_223: got %0b want 0", pixel); end
    y = 10'd228; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL move_pixel_228: got %0b want 0", pixel); end
  endtask

  // Continues from test_spawn: bullet at by=224 after one move.
  task automatic test_flight();
    ship_x = 10'd300;
    repeat (56) step();
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL flight_count57: got %0d want 1", active_count); end
    x = 10'd100; y = 10'd0; #1;
    total++; if (pixel !== 1'b1) begin bad++; $display("FAIL flight_pixel_y0: got %0b want 1", pixel); end
    y = 10'd3; #1;
    total++; if (pixel !== 1'b1) begin bad++; $display("FAIL flight_pixel_y3: got %0b want 1", pixel); end
    y = 10'd4; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL flight_pixel_y4: got %0b want 0", pixel); end
    x = 10'd300; y = 10'd0; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL flight_ship_moved: got %0b want 0", pixel); end
    step();
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL retire_count: got %0d want 0", active_count); end
    x = 10'd100; y = 10'd0; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL retire_pixel: got %0b want 0", pixel); end
  endtask

  task automatic test_cooldown();
    do_reset();
    ship_x = 10'd50;
    for (int t = 0; t <= 9; t++) begin
      fire = (t == 0) || (t == 5) || (t == 9);
      step();
      if (t == 0) begin
        total++; if (shot_fired !== 1'b1) begin bad++; $display("FAIL cd_first: got %0b want 1", shot_fired); end
      end
      if (t == 1) begin
        total++; if (shot_fired !== 1'b0) begin bad++; $display("FAIL cd_pulse: got %0b want 0", shot_fired); end
      end
      if (t == 5) begin
        total++; if (shot_fired !== 1'b0) begin bad++; $display("FAIL cd_reject5: got %0b want 0", shot_fired); end
        total++; if (active_count !== 4'd1) begin bad++; $display("FAIL cd_count5: got %0d want 1", active_count); end
      end
      if (t == 9) begin
        total++; if (shot_fired !== 1'b1) begin bad++; $display("FAIL cd_accept9: got %0b want 1", shot_fired); end
        total++; if (active_count !== 4'd2) begin bad++; $display("FAIL cd_count9: got %0d want 2", active_count); end
      end
    end
    fire = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    for (int t = 0; t <= 68; t++) begin
      ship_x = (t == 68) ? 10'd400 : 10'(10 + t);
      fire   = ((t % 9 == 0) && (t <= 36)) || (t == 68);
      step();
      if (t == 27) begin
        total++; if (active_count !== 4'd4) begin bad++; $display("FAIL full_count27: got %0d want 4", active_count); end
      end
      if (t == 36) begin
        total++; if (shot_fired !== 1'b0) begin bad++; $display("FAIL full_reject: got %0b want 0", shot_fired); end
        total++; if (active_count !== 4'd4) begin bad++; $display("FAIL full_count36: got %0d want 4", active_count); end
      end
      if (t == 57) begin
        total++; if (active_count !== 4'd4) begin bad++; $display("FAIL full_count57: got %0d want 4", active_count); end
      end
      if (t == 58) begin
        total++; if (active_count !== 4'd3) begin bad++; $display("FAIL full_count58: got %0d want 3", active_count); end
      end
      if (t == 67) begin
        total++; if (active_count !== 4'd2) begin bad++; $display("FAIL full_count67: got %0d want 2", active_count); end
      end
      if (t == 68) begin
        total++; if (shot_fired !== 1'b1) begin bad++; $display("FAIL full_refire: got %0b want 1", shot_fired); end
        total++; if (active_count !== 4'd3) begin bad++; $display("FAIL full_count68: got %0d want 3", active_count); end
        total++; if (dut.g_slot[0].u_slot.active_q !== 1'b1) begin bad++; $display("FAIL full_slot0: got %0b want 1", dut.g_slot[0].u_slot.active_q); end
        total++; if (dut.g_slot[1].u_slot.active_q !== 1'b0) begin bad++; $display("FAIL full_slot1: got %0b want 0", dut.g_slot[1].u_slot.active_q); end
        x = 10'd400; y = 10'd228; #1;
        total++; if (pixel !== 1'b1) begin bad++; $display("FAIL full_new_pixel: got %0b want 1", pixel); end
      end
    end
    fire = 1'b0;
  endtask

  task automatic test_held();
    int shots;
    logic exp;
    do_reset();
    shots = 0;
`ifdef BULLET_AUTOFIRE_EN
    for (int t = 0; t < 40; t++) begin
      fire = 1'b1;
      step();
      exp = (t == 0) || (t == 9) || (t == 18) || (t == 27);
      total++; if (shot_fired !== exp) begin bad++; $display("FAIL held_auto t=%0d: got %0b want %0b", t, shot_fired, exp); end
      if (shot_fired === 1'b1) shots++;
    end
    total++; if (shots !== 4) begin bad++; $display("FAIL held_shots: got %0d want 4", shots); end
    total++; if (active_count !== 4'd4) begin bad++; $display("FAIL held_count: got %0d want 4", active_count); end
`else
    for (int t = 0; t < 40; t++) begin
      fire  = 1'b1;
      reset = (t == 10) || (t == 11);
      step();
      if (shot_fired === 1'b1) shots++;
      if (t == 0) begin
        exp = 1'b1;
        total++; if (shot_fired !== exp) begin bad++; $display("FAIL held_first: got %0b want %0b", shot_fired, exp); end
      end
      if (t == 12) begin
        total++; if (shot_fired !== 1'b0) begin bad++; $display("FAIL held_after_reset: got %0b want 0", shot_fired); end
      end
    end
    total++; if (shots !== 1) begin bad++; $display("FAIL held_shots: got %0d want 1", shots); end
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL held_count: got %0d want 0", active_count); end
`endif
    fire  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int t = 0; t <= 18; t++) begin
      ship_x = (t == 0) ? 10'd10 : ((t == 9) ? 10'd20 : 10'd30);
      fire   = (t == 0) || (t == 9) || (t == 18);
      step();
    end
    total++; if (active_count !== 4'd3) begin bad++; $display("FAIL mid_count: got %0d want 3", active_count); end
    x = 10'd10; y = 10'd156; #1;
    total++; if (pixel !== 1'b1) begin bad++; $display("FAIL mid_b0: got %0b want 1", pixel); end
    x = 10'd20; y = 10'd192; #1;
    total++; if (pixel !== 1'b1) begin bad++; $display("FAIL mid_b1: got %0b want 1", pixel); end
    x = 10'd30; y = 10'd228; #1;
    total++; if (pixel !== 1'b1) begin bad++; $display("FAIL mid_b2: got %0b want 1", pixel); end
    fire  = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL mid_reset_count: got %0d want 0", active_count); end
    x = 10'd10; y = 10'd156; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL mid_reset_b0: got %0b want 0", pixel); end
    x = 10'd30; y = 10'd228; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL mid_reset_b2: got %0b want 0", pixel); end
    x = 10'd0; y = 10'd0; #1;
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL mid_reset_origin: got %0b want 0", pixel); end
    fire = 1'b1;
    step();
    total++; if (shot_fired !== 1'b1) begin bad++; $display("FAIL mid_refire: got %0b want 1", shot_fired); end
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL mid_refire_count: got %0d want 1", active_count); end
    fire = 1'b0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_spawn();
    test_flight();
    test_cooldown();
    test_full();
    test_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_launcher.md
Name: bullet_launcher

Overview:
Consumes the ship's horizontal position and the player's fire button, and spawns and moves projectiles upward from the ship's nose at one step per 60 Hz frame tick. It also produces the bullet layer of the pixel stream for the current (x, y) scan coordinate, which is OR-ed with the ship pixel in the display mux. The block is the downstream consumer of the ship's X position output.

Parameters:
MAX_BULLETS, 4, number of bullet slots (1..8)
SPEED, 4, pixels moved upward per clk_60hz tick
COOLDOWN, 8, ticks loaded into the refire counter after a shot
SHIP_Y, 240, fixed ship row
NOSE_OFFSET, 12, spawn row offset above SHIP_Y
BULLET_H, 4, bullet height in pixels (width is 1 pixel)

Ports:
clk_60hz  input  1  frame-rate clock
reset  input  1  synchronous, active-high
fire  input  1  fire button level (already synchronised)
ship_x  input  10  current ship X position
x  input  10  scan X coordinate
y  input  10  scan Y coordinate
pixel  output  1  bullet pixel at (x, y), combinational from registered state
active_count  output  4  number of active slots
shot_fired  output  1  one-tick pulse when a bullet is spawned

Behaviour:
- Reset (sync): all slots inactive; bx, by = 0; cooldown = 0; shot_fired = 0; active_count = 0; pixel = 0.
- During reset, fire_d <= fire, so a fire held high through reset does not produce a shot.
- Fire request:
  - Edge-only mode: request = fire & ~fire_d.
  - fire_d is updated every tick.
- Spawn conditions: request && cooldown == 0 && at least one free slot.
- On spawn:
  - The lowest-index free slot becomes active, with bx = ship_x and by = SHIP_Y - NOSE_OFFSET (228 at default parameters).
  - cooldown <= COOLDOWN.
  - shot_fired = 1 for that tick only; the pulse is registered and coincides with the slot becoming active.
- Spawned bullets do not move on their spawn tick.
- Refused request (all slots full, or cooldown != 0):
  - The request is dropped and not queued.
  - shot_fired = 0 and cooldown is not reloaded.
- Cooldown: when no shot occurs, cooldown decrements by 1 per tick and saturates at 0. Minimum spacing between shots is therefore COOLDOWN+1 ticks.
- Movement, for each active slot not spawned this tick:
  - If by < SPEED, the slot becomes inactive (retire).
  - Otherwise by <= by - SPEED.
  - Position arithmetic is unsigned 10-bit and can never wrap.
- A slot retiring and the same slot being reallocated in the same tick do not happen together: allocation only considers slots that are free at the start of the tick.
- active_count: registered popcount of the slot active bits after each tick's update.
- pixel = 1 iff some slot is active with x == bx and by <= y <= by + BULLET_H - 1. The upper bound is computed in 11 bits so it cannot overflow.
- ship_x is sampled only at spawn; later ship motion does not affect bullets already in flight.

Optional Feature:
- Macro: BULLET_AUTOFIRE_EN.
- When defined: request = fire (level-sensitive), so holding fire shoots every COOLDOWN+1 ticks while a slot is free.
- When undefined: edge-only firing as described above.
- All other behaviour is identical in both modes.

Decomposition:
- Shared package asteroids_pkg holds:
  - coord_t (10-bit unsigned)
  - SCREEN_W = 640, SCREEN_H = 480
  - SHIP_Y default
- Sub-module bullet_slot is instantiated MAX_BULLETS times:
  - Inputs: spawn, spawn_x, spawn_y.
  - Outputs: active, bx, by, and a hit test for (x, y).
  - Internals: the slot's registers plus its move/retire logic.
- The top level handles edge detection, cooldown, priority allocation, popcount and the OR-reduction of the pixel outputs.

Test Plan:
- Spawn: reset, ship_x = 100, one fire pulse. Expect shot_fired = 1 for one tick, slot0 at (100, 228), active_count = 1, and pixel = 1 at (100, 228..231) and 0 at (101, 228).
- Flight and retire: a single bullet moves to by = 224 on the next tick. Expect by = 0 after 57 ticks and active_count = 0 after the 58th tick.
- Cooldown: fire pulses 5 ticks apart. Expect the second pulse rejected (shot_fired = 0); a pulse 9 ticks after the first is accepted.
- Full: 5 accepted-timing pulses spaced 9 ticks apart with MAX_BULLETS = 4. Expect the 5th to produce no shot_fired, active_count stays 4, and the lowest free slot is used after the first retire.
- Held fire: fire held high for 40 ticks, including across a reset assertion. Expect exactly 1 shot in edge mode and 0 shots immediately after reset. With BULLET_AUTOFIRE_EN, expect shots at ticks 0, 9, 18, 27.
- Reset mid-flight: 3 active bullets, then assert reset. Expect active_count = 0 and pixel = 0 everywhere on the next tick, with cooldown cleared so an immediate fire edge after reset is accepted.
